// File: rtl/fecha_ctrl_pkg.sv
`default_nettype none
// =============================================================================
//  Module      : fecha_ctrl_pkg
//  Description : Shared state encodings, date-block capture selects and
//                default RTC register addresses for the date sequencer.
//  Revision    : 1.0 - initial release
// =============================================================================
package fecha_ctrl_pkg;

   // Sequencer states
   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_RD_DIA = 4'd1,
      ST_RD_MES = 4'd2,
      ST_RD_ANO = 4'd3,
      ST_CAP    = 4'd4,
      ST_EDIT   = 4'd5,
      ST_WR_DIA = 4'd6,
      ST_WR_MES = 4'd7,
      ST_WR_ANO = 4'd8
   } estado_t;

   // Date-block capture selects
   localparam logic [3:0] SEL_DIA  = 4'd0;
   localparam logic [3:0] SEL_MES  = 4'd1;
   localparam logic [3:0] SEL_ANO  = 4'd2;
   localparam logic [3:0] SEL_EDIT = 4'd4;
   localparam logic [3:0] SEL_HOLD = 4'd6;

   // Default RTC register map
   localparam logic [7:0] ADDR_DIA_DEF = 8'h24;
   localparam logic [7:0] ADDR_MES_DEF = 8'h25;
   localparam logic [7:0] ADDR_ANO_DEF = 8'h26;

   localparam int unsigned TIMEOUT_DEF = 255;

   // Field index (0 day, 1 month, 2 year) to capture select
   function automatic logic [3:0] sel_campo(input logic [1:0] campo);
      case (campo)
         2'd0:    sel_campo = SEL_DIA;
         2'd1:    sel_campo = SEL_MES;
         2'd2:    sel_campo = SEL_ANO;
         default: sel_campo = SEL_HOLD;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/cont_timeout.sv
`default_nettype none
// =============================================================================
//  Module      : cont_timeout
//  Description : 8-bit up counter measuring how long an RTC request has been
//                pending. tc_o flags the LIMIT-th enabled cycle since clear.
//  Revision    : 1.0 - initial release
// =============================================================================
module cont_timeout #(
   parameter int unsigned LIMIT = 255
) (
   input  logic reloj,
   input  logic resetM,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   logic [7:0] cnt_q;

   // Count enabled cycles; clear has priority over enable
   always_ff @(posedge reloj) begin
      if (!resetM) begin
         cnt_q <= 8'd0;
      end else if (clr_i) begin
         cnt_q <= 8'd0;
      end else if (en_i) begin
         cnt_q <= cnt_q + 8'd1;
      end
   end

   // Counter holds k-1 during the k-th enabled cycle
   assign tc_o = en_i && (cnt_q == 8'(LIMIT - 1));

endmodule
`default_nettype wire

// File: rtl/fecha_ctrl_secuenciador.sv
`default_nettype none
// =============================================================================
//  Module      : fecha_ctrl_secuenciador
//  Description : Sequencer for the day/month/year date block. Periodically
//                reads the date from the RTC, enters edit mode on the program
//                key and writes the edited date back on the second key press.
//  Revision    : 1.0 - initial release
// =============================================================================
module fecha_ctrl_secuenciador
   import fecha_ctrl_pkg::*;
#(
   parameter logic [7:0]  ADDR_DIA    = ADDR_DIA_DEF,
   parameter logic [7:0]  ADDR_MES    = ADDR_MES_DEF,
   parameter logic [7:0]  ADDR_ANO    = ADDR_ANO_DEF,
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEF
) (
   input  logic       reloj,
   input  logic       resetM,
   input  logic       tick_lectura,
   input  logic       btn_prog,
   input  logic       rtc_ack,
   input  logic [7:0] OUT_diaf,
   input  logic [7:0] OUT_mesf,
   input  logic [7:0] OUT_anof,
   output logic       rtc_req,
   output logic       rtc_wr,
   output logic [7:0] rtc_addr,
   output logic [7:0] rtc_wdata,
   output logic [3:0] Selec_Demux_DD,
   output logic       READ,
   output logic       enable_cont_fecha,
   output logic       enable_cont_16,
   output logic       modo_edicion,
   output logic       err_timeout
);

   estado_t    estado_q, estado_d;
   logic [1:0] campo_q, campo_d;
   logic       req_q, req_d;
   logic       wr_q, wr_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic [3:0] sel_q, sel_d;
   logic       read_q, read_d;
   logic       edit_q, edit_d;
   logic       err_q, err_d;
   logic       w_tc;

   // Pending-request watchdog: cleared while no request is outstanding
   cont_timeout #(
      .LIMIT (TIMEOUT_CYC)
   ) u_cont_timeout (
      .reloj  (reloj),
      .resetM (resetM),
      .clr_i  (~req_q),
      .en_i   (req_q),
      .tc_o   (w_tc)
   );

   // Next state and RTC bus fields; an ack in the terminal cycle wins
   always_comb begin
      estado_d = estado_q;
      campo_d  = campo_q;
      req_d    = req_q;
      wr_d     = wr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      err_d    = err_q;
      case (estado_q)
         ST_IDLE: begin
            if (btn_prog) begin
               estado_d = ST_EDIT;
               err_d    = 1'b0;
            end else if (tick_lectura) begin
               estado_d = ST_RD_DIA;
               req_d    = 1'b1;
               wr_d     = 1'b0;
               addr_d   = ADDR_DIA;
            end
         end
         ST_RD_DIA, ST_RD_MES, ST_RD_ANO: begin
            if (rtc_ack) begin
               estado_d = ST_CAP;
               req_d    = 1'b0;
               case (estado_q)
                  ST_RD_DIA: campo_d = 2'd0;
                  ST_RD_MES: campo_d = 2'd1;
                  default:   campo_d = 2'd2;
               endcase
            end else if (w_tc) begin
               estado_d = ST_IDLE;
               req_d    = 1'b0;
               err_d    = 1'b1;
            end
         end
         ST_CAP: begin
            case (campo_q)
               2'd0: begin
                  estado_d = ST_RD_MES;
                  req_d    = 1'b1;
                  addr_d   = ADDR_MES;
               end
               2'd1: begin
                  estado_d = ST_RD_ANO;
                  req_d    = 1'b1;
                  addr_d   = ADDR_ANO;
               end
               default: begin
                  estado_d = ST_IDLE;
               end
            endcase
         end
         ST_EDIT: begin
            if (btn_prog) begin
               estado_d = ST_WR_DIA;
               req_d    = 1'b1;
               wr_d     = 1'b1;
               addr_d   = ADDR_DIA;
               wdata_d  = OUT_diaf;
               err_d    = 1'b0;
            end
         end
         ST_WR_DIA, ST_WR_MES, ST_WR_ANO: begin
            // Between writes the request rests low for one cycle
            if (!req_q) begin
               req_d = 1'b1;
            end else if (rtc_ack) begin
               req_d = 1'b0;
               case (estado_q)
                  ST_WR_DIA: begin
                     estado_d = ST_WR_MES;
                     addr_d   = ADDR_MES;
                     wdata_d  = OUT_mesf;
                  end
                  ST_WR_MES: begin
                     estado_d = ST_WR_ANO;
                     addr_d   = ADDR_ANO;
                     wdata_d  = OUT_anof;
                  end
                  default: begin
                     estado_d = ST_IDLE;
                     wr_d     = 1'b0;
                  end
               endcase
            end else if (w_tc) begin
               estado_d = ST_IDLE;
               req_d    = 1'b0;
               wr_d     = 1'b0;
               err_d    = 1'b1;
            end
         end
         default: begin
            estado_d = ST_IDLE;
            req_d    = 1'b0;
         end
      endcase
   end

   // Date-block controls decoded from the upcoming state so they register in step
   always_comb begin
      sel_d  = SEL_HOLD;
      read_d = 1'b1;
      edit_d = 1'b0;
      case (estado_d)
         ST_CAP: begin
            sel_d = sel_campo(campo_d);
         end
         ST_EDIT: begin
            sel_d  = SEL_EDIT;
            read_d = 1'b0;
            edit_d = 1'b1;
         end
         ST_WR_DIA, ST_WR_MES, ST_WR_ANO: begin
            read_d = 1'b0;
         end
         default: begin
            sel_d = SEL_HOLD;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge reloj) begin
      if (!resetM) begin
         estado_q <= ST_IDLE;
         campo_q  <= 2'd0;
         req_q    <= 1'b0;
         wr_q     <= 1'b0;
         addr_q   <= 8'd0;
         wdata_q  <= 8'd0;
         sel_q    <= SEL_HOLD;
         read_q   <= 1'b1;
         edit_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         estado_q <= estado_d;
         campo_q  <= campo_d;
         req_q    <= req_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         sel_q    <= sel_d;
         read_q   <= read_d;
         edit_q   <= edit_d;
         err_q    <= err_d;
      end
   end

   assign rtc_req           = req_q;
   assign rtc_wr            = wr_q;
   assign rtc_addr          = addr_q;
   assign rtc_wdata         = wdata_q;
   assign Selec_Demux_DD    = sel_q;
   assign READ              = read_q;
   assign enable_cont_fecha = edit_q;
   assign enable_cont_16    = edit_q;
   assign modo_edicion      = edit_q;
   assign err_timeout       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fecha_ctrl_secuenciador.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
//  Module      : tb_fecha_ctrl_secuenciador
//  Description : Self-checking bench for the date sequencer: directed steps
//                with randomized latencies and data, an RTC responder and a
//                date-block model.
//  Revision    : 1.0 - initial release
// =============================================================================
module tb_fecha_ctrl_secuenciador;

   localparam int TO = 8;

   logic       reloj = 1'b0;
   logic       resetM = 1'b0;
   logic       tick_lectura = 1'b0;
   logic       btn_prog = 1'b0;
   logic       rtc_ack = 1'b0;
   logic [7:0] OUT_diaf = 8'h00;
   logic [7:0] OUT_mesf = 8'h00;
   logic [7:0] OUT_anof = 8'h00;
   logic       rtc_req;
   logic       rtc_wr;
   logic [7:0] rtc_addr;
   logic [7:0] rtc_wdata;
   logic [3:0] Selec_Demux_DD;
   logic       READ;
   logic       enable_cont_fecha;
   logic       enable_cont_16;
   logic       modo_edicion;
   logic       err_timeout;

   logic [7:0] rtc_rdata = 8'h00;
   logic [7:0] blk_dia = 8'h00;
   logic [7:0] blk_mes = 8'h00;
   logic [7:0] blk_ano = 8'h00;
   logic [7:0] addr_tab [3] = '{8'h24, 8'h25, 8'h26};

   int checks = 0;
   int failures = 0;

   always #5 reloj = ~reloj;

   fecha_ctrl_secuenciador #(
      .ADDR_DIA    (8'h24),
      .ADDR_MES    (8'h25),
      .ADDR_ANO    (8'h26),
      .TIMEOUT_CYC (TO)
   ) dut (
      .reloj             (reloj),
      .resetM            (resetM),
      .tick_lectura      (tick_lectura),
      .btn_prog          (btn_prog),
      .rtc_ack           (rtc_ack),
      .OUT_diaf          (OUT_diaf),
      .OUT_mesf          (OUT_mesf),
      .OUT_anof          (OUT_anof),
      .rtc_req           (rtc_req),
      .rtc_wr            (rtc_wr),
      .rtc_addr          (rtc_addr),
      .rtc_wdata         (rtc_wdata),
      .Selec_Demux_DD    (Selec_Demux_DD),
      .READ              (READ),
      .enable_cont_fecha (enable_cont_fecha),
      .enable_cont_16    (enable_cont_16),
      .modo_edicion      (modo_edicion),
      .err_timeout       (err_timeout)
   );

   // Date block: captures the RTC read data according to the select
   always @(posedge reloj) begin
      if (resetM) begin
         case (Selec_Demux_DD)
            4'd0: blk_dia <= rtc_rdata;
            4'd1: blk_mes <= rtc_rdata;
            4'd2: blk_ano <= rtc_rdata;
            default: ;
         endcase
      end
   end

   task automatic step();
      @(posedge reloj);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_req(input string tag);
      int n = 0;
      while (rtc_req !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk({tag, "_req_seen"}, {7'd0, rtc_req}, 8'd1);
   endtask

   // One RTC transaction: ack arrives in the lat-th cycle of the request
   task automatic serve(input string tag, input bit exp_wr, input logic [7:0] exp_addr,
                        input logic [7:0] exp_wd, input int lat, input logic [7:0] rd,
                        input int scr, input bit noise);
      bit bad = 1'b0;
      wait_req(tag);
      case (scr)
         0: OUT_diaf = ~OUT_diaf;
         1: OUT_mesf = ~OUT_mesf;
         2: OUT_anof = ~OUT_anof;
         default: ;
      endcase
      chk({tag, "_addr"}, rtc_addr, exp_addr);
      chk({tag, "_wr"}, {7'd0, rtc_wr}, {7'd0, exp_wr});
      if (exp_wr) chk({tag, "_wdata"}, rtc_wdata, exp_wd);
      if (noise) btn_prog = 1'b1;
      for (int i = 1; i <= lat; i++) begin
         if (rtc_req !== 1'b1 || rtc_addr !== exp_addr || rtc_wr !== exp_wr ||
             (exp_wr && rtc_wdata !== exp_wd)) bad = 1'b1;
         if (i == lat) begin
            rtc_ack   = 1'b1;
            rtc_rdata = rd;
         end
         step();
         btn_prog = 1'b0;
         rtc_ack  = 1'b0;
      end
      chk({tag, "_hold"}, {7'd0, bad}, 8'd0);
      chk({tag, "_req_drop"}, {7'd0, rtc_req}, 8'd0);
   endtask

   // Full read: three requests, each followed by a one-cycle capture select
   task automatic run_read(input string tag, input int l0, input int l1, input int l2,
                           input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                           input bit noise);
      int         lat [3];
      logic [7:0] dat [3];
      lat = '{l0, l1, l2};
      dat = '{d0, d1, d2};
      tick_lectura = 1'b1;
      step();
      tick_lectura = 1'b0;
      for (int f = 0; f < 3; f++) begin
         serve($sformatf("%s_rd%0d", tag, f), 1'b0, addr_tab[f], 8'h00, lat[f], dat[f], -1, noise);
         chk($sformatf("%s_cap%0d", tag, f), {4'd0, Selec_Demux_DD}, f[7:0]);
         step();
         chk($sformatf("%s_hold%0d", tag, f), {4'd0, Selec_Demux_DD}, 8'd6);
      end
      chk({tag, "_idle_req"}, {7'd0, rtc_req}, 8'd0);
      chk({tag, "_read"}, {7'd0, READ}, 8'd1);
      chk({tag, "_modo"}, {7'd0, modo_edicion}, 8'd0);
      chk({tag, "_dia"}, blk_dia, d0);
      chk({tag, "_mes"}, blk_mes, d1);
      chk({tag, "_ano"}, blk_ano, d2);
   endtask

   task automatic check_edit(input string tag);
      chk({tag, "_read"}, {7'd0, READ}, 8'd0);
      chk({tag, "_sel"}, {4'd0, Selec_Demux_DD}, 8'd4);
      chk({tag, "_enf"}, {7'd0, enable_cont_fecha}, 8'd1);
      chk({tag, "_en16"}, {7'd0, enable_cont_16}, 8'd1);
      chk({tag, "_modo"}, {7'd0, modo_edicion}, 8'd1);
      chk({tag, "_req"}, {7'd0, rtc_req}, 8'd0);
   endtask

   // From EDIT: present edited values, press the key, serve three writes
   task automatic do_writes(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                            input logic [7:0] w2);
      logic [7:0] w [3];
      w = '{w0, w1, w2};
      OUT_diaf = w0;
      OUT_mesf = w1;
      OUT_anof = w2;
      btn_prog = 1'b1;
      step();
      btn_prog = 1'b0;
      chk({tag, "_wr_read"}, {7'd0, READ}, 8'd0);
      chk({tag, "_wr_enf"}, {7'd0, enable_cont_fecha}, 8'd0);
      chk({tag, "_wr_en16"}, {7'd0, enable_cont_16}, 8'd0);
      chk({tag, "_wr_modo"}, {7'd0, modo_edicion}, 8'd0);
      for (int f = 0; f < 3; f++) begin
         serve($sformatf("%s_wr%0d", tag, f), 1'b1, addr_tab[f], w[f],
               int'($urandom_range(1, TO)), 8'h00, f, 1'b0);
         if (f < 2) begin
            chk($sformatf("%s_gap%0d", tag, f), {7'd0, READ}, 8'd0);
            step();
            chk($sformatf("%s_rereq%0d", tag, f), {7'd0, rtc_req}, 8'd1);
         end
      end
      chk({tag, "_end_read"}, {7'd0, READ}, 8'd1);
      chk({tag, "_end_sel"}, {4'd0, Selec_Demux_DD}, 8'd6);
   endtask

   task automatic enter_edit(input string tag);
      btn_prog = 1'b1;
      step();
      btn_prog = 1'b0;
      check_edit(tag);
   endtask

   initial begin
      int n;
      // Reset held for three cycles
      resetM = 1'b0;
      repeat (3) step();
      chk("rst_req", {7'd0, rtc_req}, 8'd0);
      chk("rst_wr", {7'd0, rtc_wr}, 8'd0);
      chk("rst_addr", rtc_addr, 8'h00);
      chk("rst_wdata", rtc_wdata, 8'h00);
      chk("rst_sel", {4'd0, Selec_Demux_DD}, 8'd6);
      chk("rst_read", {7'd0, READ}, 8'd1);
      chk("rst_enf", {7'd0, enable_cont_fecha}, 8'd0);
      chk("rst_en16", {7'd0, enable_cont_16}, 8'd0);
      chk("rst_modo", {7'd0, modo_edicion}, 8'd0);
      chk("rst_err", {7'd0, err_timeout}, 8'd0);
      resetM = 1'b1;
      step();

      // Directed read with fixed data, then randomized reads
      run_read("t2", 4, 4, 4, 8'h29, 8'h10, 8'h99, 1'b0);
      run_read("rdmax", TO, 1, TO, 8'h31, 8'h12, 8'h00, 1'b1);
      for (int k = 0; k < 3; k++) begin
         step();
         run_read($sformatf("rr%0d", k), int'($urandom_range(1, TO)), int'($urandom_range(1, TO)),
                  int'($urandom_range(1, TO)), 8'($urandom), 8'($urandom), 8'($urandom),
                  1'($urandom));
      end

      // Stray ack while idle
      rtc_ack = 1'b1;
      step();
      rtc_ack = 1'b0;
      step();
      chk("idle_ack_req", {7'd0, rtc_req}, 8'd0);
      chk("idle_ack_sel", {4'd0, Selec_Demux_DD}, 8'd6);

      // Edit and write-back; tick and ack ignored in edit
      enter_edit("t3");
      tick_lectura = 1'b1;
      rtc_ack = 1'b1;
      step();
      tick_lectura = 1'b0;
      rtc_ack = 1'b0;
      step();
      check_edit("t3_ign");
      do_writes("t3", 8'h15, 8'h04, 8'h17);
      step();
      enter_edit("t3r");
      do_writes("t3r", 8'($urandom), 8'($urandom), 8'($urandom));

      // Key and tick together in idle
      step();
      btn_prog = 1'b1;
      tick_lectura = 1'b1;
      step();
      btn_prog = 1'b0;
      tick_lectura = 1'b0;
      check_edit("t4");
      n = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (rtc_req !== 1'b0) n++;
      end
      chk("t4_noreq", 8'(n), 8'd0);
      do_writes("t4", 8'h01, 8'h02, 8'h03);

      // Timeout: no ack ever
      step();
      tick_lectura = 1'b1;
      step();
      tick_lectura = 1'b0;
      wait_req("t5");
      n = 0;
      while (rtc_req === 1'b1 && n < 300) begin
         step();
         n++;
      end
      chk("t5_cycles", 8'(n), 8'(TO));
      chk("t5_err", {7'd0, err_timeout}, 8'd1);
      chk("t5_read", {7'd0, READ}, 8'd1);
      chk("t5_sel", {4'd0, Selec_Demux_DD}, 8'd6);
      repeat (3) step();
      chk("t5_err_sticky", {7'd0, err_timeout}, 8'd1);
      chk("t5_idle_req", {7'd0, rtc_req}, 8'd0);
      enter_edit("t5_edit");
      chk("t5_err_clr", {7'd0, err_timeout}, 8'd0);
      do_writes("t5", 8'h28, 8'h02, 8'h24);

      // Reset while waiting on the month read
      step();
      tick_lectura = 1'b1;
      step();
      tick_lectura = 1'b0;
      serve("t6_dia", 1'b0, 8'h24, 8'h00, 2, 8'h07, -1, 1'b0);
      step();
      wait_req("t6_mes");
      chk("t6_mes_addr", rtc_addr, 8'h25);
      step();
      resetM = 1'b0;
      step();
      chk("t6_req", {7'd0, rtc_req}, 8'd0);
      chk("t6_sel", {4'd0, Selec_Demux_DD}, 8'd6);
      chk("t6_read", {7'd0, READ}, 8'd1);
      resetM = 1'b1;
      step();
      run_read("t6_after", int'($urandom_range(1, TO)), 3, 2, 8'h11, 8'h05, 8'h42, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Absolute guard against a stuck run
   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
